// File: rtl/sprite_scaler.sv
// sprite_scaler: places one ROM sprite at (pos_x,pos_y) with integer
// magnification and transparency, and composites it over the background.
// The ROM address comes from incremental texel/repeat counters, so the pixel
// path has no multipliers or dividers.
// Optional feature macro: SPRITE_SCALER_MIRROR_EN (horizontal mirroring).
module sprite_scaler #(
  parameter int SPR_W      = 43,
  parameter int SPR_H      = 50,
  parameter int ADDR_W     = 12,
  parameter int IDX_W      = 9,
  parameter int SCALE_W    = 3,
  parameter int TRANSP_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              enable,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [SCALE_W-1:0] scale,
  input  logic              mirror_x,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_hit
);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);

  typedef enum logic [1:0] {V_WAIT, V_ACTIVE, V_DONE} vst_t;
  typedef enum logic [1:0] {H_WAIT, H_ACTIVE, H_DONE} hst_t;

  // Frame start and line start; on the frame-start cycle the live inputs are
  // used directly so a sprite at (0,0) is drawn from its first pixel.
  logic fs, lstart;
  assign lstart = (DrawX == 10'd0);
  assign fs     = lstart && (DrawY == 10'd0);

  logic               en_q, en_c;
  logic [9:0]         px_q, px_c, py_q, py_c;
  logic [SCALE_W-1:0] sc_q, sc_c, scm1;

  assign en_c = fs ? (enable && (pos_x < 10'd640) && (pos_y < 10'd480)) : en_q;
  assign px_c = fs ? pos_x : px_q;
  assign py_c = fs ? pos_y : py_q;
  assign sc_c = fs ? ((scale == '0) ? SCALE_W'(1) : scale) : sc_q;
  assign scm1 = sc_c - 1'b1;

  logic [CW-1:0] cstart, cend;
`ifdef SPRITE_SCALER_MIRROR_EN
  logic mir_q, mir_c;
  assign mir_c  = fs ? mirror_x : mir_q;
  assign cstart = mir_c ? CW'(SPR_W-1) : '0;
  assign cend   = mir_c ? '0 : CW'(SPR_W-1);
  // Shadow mirror flag, refreshed at frame start only.
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) mir_q <= 1'b0;
    else          mir_q <= mir_c;
`else
  logic unused_mirror;
  assign unused_mirror = mirror_x;
  assign cstart = '0;
  assign cend   = CW'(SPR_W-1);
`endif

  // Shadow configuration, refreshed at frame start only.
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      en_q <= 1'b0; px_q <= '0; py_q <= '0; sc_q <= SCALE_W'(1);
    end else begin
      en_q <= en_c; px_q <= px_c; py_q <= py_c; sc_q <= sc_c;
    end

  // Vertical and horizontal state; the _d values also describe the current pixel.
  vst_t               v_q, v_d;
  logic [SCALE_W-1:0] vrep_q, vrep_d, hrep_q, hrep_d, hrep_c;
  logic [RW-1:0]      trow_q, trow_d;
  logic [ADDR_W-1:0]  row_q, row_d, addr_q, addr_d;
  hst_t               h_q, h_d, h_b;
  logic [CW-1:0]      col_q, col_d, col_c;
  logic               h_start, in_c;

  // Vertical FSM: advances only at line start, one texel row per scale lines.
  always_comb begin
    v_d = v_q; vrep_d = vrep_q; trow_d = trow_q; row_d = row_q;
    if (lstart) begin
      if (fs) begin
        v_d = V_WAIT; vrep_d = '0; trow_d = '0; row_d = '0;
      end
      case (v_d)
        V_WAIT:
          if (DrawY == py_c) begin
            v_d = V_ACTIVE; vrep_d = '0; trow_d = '0; row_d = '0;
          end
        V_ACTIVE:
          if (vrep_d == scm1) begin
            if (trow_d == RW'(SPR_H-1)) v_d = V_DONE;
            else begin
              vrep_d = '0;
              trow_d = trow_d + 1'b1;
              row_d  = row_d + ADDR_W'(SPR_W);
            end
          end else vrep_d = vrep_d + 1'b1;
        default: ;
      endcase
    end
  end

  // Horizontal FSM and ROM address; a line start always drops back to wait,
  // which clips a sprite running off the right edge.
  always_comb begin
    h_b     = lstart ? H_WAIT : h_q;
    h_start = (h_b == H_WAIT) && (v_d == V_ACTIVE) && en_c && (DrawX == px_c);
    in_c    = h_start || (h_b == H_ACTIVE);
    col_c   = h_start ? cstart : col_q;
    hrep_c  = h_start ? '0 : hrep_q;
    h_d = h_b; col_d = col_q; hrep_d = hrep_q; addr_d = addr_q;
    if (in_c) begin
      addr_d = row_d + ADDR_W'(col_c);
      h_d    = H_ACTIVE;
      col_d  = col_c;
      hrep_d = hrep_c + 1'b1;
      if (hrep_c == scm1) begin
        hrep_d = '0;
        if (col_c == cend) h_d = H_DONE;
`ifdef SPRITE_SCALER_MIRROR_EN
        else col_d = mir_c ? col_c - 1'b1 : col_c + 1'b1;
`else
        else col_d = col_c + 1'b1;
`endif
      end
    end
  end

  // State registers for both FSMs and the ROM address.
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      v_q <= V_WAIT; vrep_q <= '0; trow_q <= '0; row_q <= '0;
      h_q <= H_WAIT; col_q <= '0; hrep_q <= '0; addr_q <= '0;
    end else begin
      v_q <= v_d; vrep_q <= vrep_d; trow_q <= trow_d; row_q <= row_d;
      h_q <= h_d; col_q <= col_d; hrep_q <= hrep_d; addr_q <= addr_d;
    end

  assign rom_address = addr_q;

  // First delay stage for blank, background and in-sprite, matching ROM latency.
  logic        bl_q, in_q;
  logic [11:0] bg_q;
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      bl_q <= 1'b0; in_q <= 1'b0; bg_q <= '0;
    end else begin
      bl_q <= blank; in_q <= in_c; bg_q <= {bg_red, bg_green, bg_blue};
    end

  // Output compositing: blanking, then opaque sprite texel, then background.
  logic [11:0] rgb_q;
  logic        hit_q;
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      rgb_q <= '0; hit_q <= 1'b0;
    end else if (!bl_q) begin
      rgb_q <= '0; hit_q <= 1'b0;
    end else if (in_q && (rom_q != IDX_W'(TRANSP_IDX))) begin
      rgb_q <= {pal_red, pal_green, pal_blue}; hit_q <= 1'b1;
    end else begin
      rgb_q <= bg_q; hit_q <= 1'b0;
    end

  assign {red, green, blue} = rgb_q;
  assign sprite_hit = hit_q;
endmodule

// File: tb/tb_sprite_scaler.sv
// Scoreboard bench for sprite_scaler: a shortened raster drives DrawX/DrawY,
// expected pixels/addresses come from a geometric sprite model.
module tb_sprite_scaler;
  localparam int W = 43, H = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  dx, dy, px, py;
  logic        blank, en, mir, hit;
  logic [2:0]  sc;
  logic [3:0]  bgr, bgg, bgb, pr, pg, pb, r, g, b;
  logic [11:0] addr;
  logic [8:0]  rom_q = 9'd0;

  sprite_scaler dut (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(dx), .DrawY(dy), .blank(blank),
    .enable(en), .pos_x(px), .pos_y(py), .scale(sc), .mirror_x(mir),
    .bg_red(bgr), .bg_green(bgg), .bg_blue(bgb), .rom_address(addr),
    .rom_q(rom_q), .pal_red(pr), .pal_green(pg), .pal_blue(pb),
    .red(r), .green(g), .blue(b), .sprite_hit(hit));

  // Sprite ROM contents: only address 5 (texel (5,0)) is transparent.
  function automatic logic [8:0] rom_fn(input int a);
    if (a == 5) return 9'd0;
    return 9'(((a * 7 + 3) % 511) + 1);
  endfunction

  always @(negedge clk) rom_q <= rom_fn(int'(addr));
  assign pr = rom_q[3:0];
  assign pg = rom_q[7:4];
  assign pb = {rom_q[8], 3'b011};

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {int due; int x; int y; logic [12:0] v;} ent_t;
  ent_t oq[$], aq[$];
  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  // Model shadow state, latched when the bench issues the frame-start pixel.
  int s_en = 0, s_px = 0, s_py = 0, s_s = 1, s_mir = 0;
  int cl[$];

  task automatic pix(input int x, input int y);
    logic bl;
    logic [8:0] idx;
    logic [12:0] ev;
    int tx, ty, a;
    bit ins;
    dx = 10'(x); dy = 10'(y);
    bl = (x < 640) && (y < 480);
    blank = bl; bgr = 4'(x); bgg = 4'(y); bgb = 4'h9;
    if (x == 0 && y == 0) begin
      s_en = int'(en); s_px = int'(px); s_py = int'(py);
      s_s = (sc == 3'd0) ? 1 : int'(sc);
`ifdef SPRITE_SCALER_MIRROR_EN
      s_mir = int'(mir);
`else
      s_mir = 0;
`endif
    end
    ins = (s_en != 0) && s_px < 640 && s_py < 480 && x >= s_px && x < s_px + W * s_s &&
          y >= s_py && y < s_py + H * s_s;
    idx = 9'd0;
    if (ins) begin
      tx = (x - s_px) / s_s; ty = (y - s_py) / s_s;
      if (s_mir != 0) tx = W - 1 - tx;
      a = ty * W + tx;
      aq.push_back('{edges + 1, x, y, 13'(a)});
      idx = rom_fn(a);
    end
    if (!bl) ev = 13'd0;
    else if (ins && idx != 9'd0) ev = {1'b1, idx[3:0], idx[7:4], idx[8], 3'b011};
    else ev = {1'b0, 4'(x), 4'(y), 4'h9};
    oq.push_back('{edges + 2, x, y, ev});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      dx = 10'd700; dy = 10'd500; blank = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  function automatic bit is_chk(input int y);
    foreach (cl[i]) if (cl[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  // One frame from line 0 to ymax; listed lines get pixels 1..xa and x0..x1.
  // At line 1 the configuration for the next frame is applied mid-frame.
  task automatic frame(input int ymax, input int xa, input int x0, input int x1,
                       input int nen, input int npx, input int npy, input int nsc, input int nmir);
    for (int y = 0; y <= ymax; y++) begin
      if (y == 1) begin
        en = nen[0]; px = 10'(npx); py = 10'(npy); sc = 3'(nsc); mir = nmir[0];
      end
      pix(0, y);
      if (is_chk(y)) begin
        for (int x = 1; x <= xa; x++) pix(x, y);
        for (int x = x0; x <= x1; x++) if (x > xa) pix(x, y);
      end
    end
  endtask

  // Monitor: pops the scoreboard entries that fall due on this edge.
  initial forever begin
    ent_t e;
    @(posedge clk); #2;
    while (aq.size() > 0 && aq[0].due <= edges) begin
      e = aq.pop_front();
      chk($sformatf("addr(%0d,%0d)", e.x, e.y), {20'd0, addr}, {19'd0, e.v});
    end
    while (oq.size() > 0 && oq[0].due <= edges) begin
      e = oq.pop_front();
      chk($sformatf("pix(%0d,%0d)", e.x, e.y), {19'd0, hit, r, g, b}, {19'd0, e.v});
    end
  end

  initial begin
    rst_n = 1'b0; dx = 10'd700; dy = 10'd500; blank = 1'b0; en = 1'b0;
    px = '0; py = '0; sc = 3'd1; mir = 1'b0; bgr = '0; bgg = '0; bgb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {20'd0, r, g, b}, 32'd0);
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_addr", {20'd0, addr}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // scale 1 at (100,50); next frame scale 3 at (200,100)
    en = 1'b1; px = 10'd100; py = 10'd50; sc = 3'd1; mir = 1'b0;
    cl = '{50, 51, 99, 100};
    frame(101, 0, 95, 150, 1, 200, 100, 3, 0);
    // scale 3: 129x150 footprint; next scale 0 at (10,20)
    cl = '{100, 101, 102, 103, 249, 250};
    frame(251, 0, 195, 335, 1, 10, 20, 0, 0);
    // scale 0 behaves as 1; next right-edge clip at (620,30) scale 2
    cl = '{20, 21, 69, 70};
    frame(71, 0, 5, 60, 1, 620, 30, 2, 0);
    // clipped sprite, line starts show no wrap; next mirrored at (300,200)
    cl = '{30, 31, 32};
    frame(33, 25, 610, 660, 1, 300, 200, 1, 1);
    // mirrored sprite (texel 42 at pos_x when mirroring is built in)
    cl = '{200, 201};
    frame(202, 0, 295, 350, 1, 650, 10, 1, 0);
    // pos_x off-screen: never visible; next frame disabled
    cl = '{10, 11};
    frame(12, 60, 640, 700, 0, 100, 50, 1, 0);
    cl = '{50};
    frame(51, 0, 95, 150, 1, 100, 50, 1, 0);

    // mid-frame reset: sprite hidden after release until the next frame start
    cl = '{50};
    frame(50, 0, 95, 150, 1, 100, 50, 1, 0);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rgb", {20'd0, r, g, b}, 32'd0);
    chk("midrst_hit", {31'd0, hit}, 32'd0);
    chk("midrst_addr", {20'd0, addr}, 32'd0);
    s_en = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int y = 51; y <= 56; y++) begin
      pix(0, y);
      if (y == 55) for (int x = 95; x <= 150; x++) pix(x, y);
    end
    cl = '{50, 51};
    frame(52, 0, 95, 150, 1, 100, 50, 1, 0);

    idle(4);
    chk("oq_drained", oq.size(), 32'd0);
    chk("aq_drained", aq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
